msb_pos_decode: RTL and testbench

- Inverse of the MSB-position finder: takes a bit position and rebuilds an N-bit word with only that bit set, plus a thermometer mask of all bits at or below it.
- Used downstream of the MSB finder to regenerate normalisation masks and leading-one values.
- The word is built iteratively: a single 1 is shifted left one place per cycle, so latency depends on the position.
- Valid/ready handshake on both input and output.

---
 rtl/msb_pos_decode_if.sv | 30 +++
 rtl/msb_pos_decode.sv | 116 +++++++++++
 tb/tb_msb_pos_decode.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msb_pos_decode_if.sv
// Handshake bundle for msb_pos_decode.
//   Request side : input_pos, input_valid (to block), input_ready (from block)
//   Result side  : output_num, output_mask, output_pos, output_err,
//                  output_valid (from block), output_ready (to block)
// slave modport is the decoder, master modport is the producer/consumer.
interface msb_pos_decode_if #(
  parameter int unsigned N = 64
);
  logic [7:0]   input_pos;
  logic         input_valid;
  logic         input_ready;
  logic [N-1:0] output_num;
  logic [N-1:0] output_mask;
  logic [7:0]   output_pos;
  logic         output_err;
  logic         output_valid;
  logic         output_ready;

  modport slave (
    input  input_pos, input_valid, output_ready,
    output input_ready, output_num, output_mask, output_pos, output_err,
           output_valid
  );

  modport master (
    output input_pos, input_valid, output_ready,
    input  input_ready, output_num, output_mask, output_pos, output_err,
           output_valid
  );
endinterface

// File: rtl/msb_pos_decode.sv
// Rebuilds a one-hot word and an at-or-below thermometer mask from a bit
// position by shifting a single 1 left once per cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : msb_pos_decode_if.slave (request + result handshakes)
// One request in flight; latency is pos+2 edges for legal positions and one
// edge for 8'hFF (no bit set) or positions >= N (flagged via output_err).
module msb_pos_decode #(
  parameter int unsigned N = 64
) (
  input  logic                clk,
  input  logic                rst,
  msb_pos_decode_if.slave     bus
);

  localparam int unsigned CW       = 8;
  localparam logic [CW:0] N_LIM    = (CW + 1)'(N);
  localparam logic [CW-1:0] POS_NONE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    num_q,   num_d;
  logic [N-1:0]    mask_q,  mask_d;
  logic [CW-1:0]   pos_q,   pos_d;
  logic            err_q,   err_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      mask_q  <= '0;
      pos_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      mask_q  <= mask_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    mask_d  = mask_q;
    pos_d   = pos_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.input_valid) begin
          pos_d = bus.input_pos;
          if (bus.input_pos == POS_NONE) begin
            num_d   = '0;
            mask_d  = '0;
            err_d   = 1'b0;
            state_d = DONE;
          end else if ({1'b0, bus.input_pos} >= N_LIM) begin
            num_d   = '0;
            mask_d  = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            // Seed bit 0; cnt counts the remaining left shifts.
            num_d   = N'(1);
            mask_d  = N'(1);
            err_d   = 1'b0;
            cnt_d   = bus.input_pos;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          num_d  = {num_q[N-2:0], 1'b0};
          mask_d = {mask_q[N-2:0], 1'b1};
          cnt_d  = cnt_q - CW'(1);
        end
      end

      DONE: begin
        if (bus.output_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake flags come straight from the state register.
  assign bus.input_ready  = (state_q == IDLE) && !rst;
  assign bus.output_valid = (state_q == DONE);
  assign bus.output_num   = num_q;
  assign bus.output_mask  = mask_q;
  assign bus.output_pos   = pos_q;
  assign bus.output_err   = err_q;

endmodule

// File: tb/tb_msb_pos_decode.sv
// Scoreboard bench for msb_pos_decode at N=64.
module tb_msb_pos_decode;

  localparam int unsigned N = 64;
  localparam int MAX_WAIT = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msb_pos_decode_if #(.N(N)) bus ();

  msb_pos_decode #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [N-1:0] num;
    logic [N-1:0] mask;
    logic [7:0]   pos;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: bit-by-bit construction of the expected result.
  function automatic exp_t model(input logic [7:0] p);
    exp_t e;
    e.num  = '0;
    e.mask = '0;
    e.pos  = p;
    e.err  = 1'b0;
    e.lat  = 1;
    if (p == 8'hFF) begin
      e.lat = 1;
    end else if (int'(p) >= int'(N)) begin
      e.err = 1'b1;
    end else begin
      e.num[p] = 1'b1;
      for (int i = 0; i <= int'(p); i++) e.mask[i] = 1'b1;
      e.lat = int'(p) + 2;
    end
    return e;
  endfunction

  // Drive one request, record its expected result, return after the accept edge.
  task automatic send(input logic [7:0] p);
    int w;
    sb.push_back(model(p));
    @(negedge clk);
    bus.input_pos   = p;
    bus.input_valid = 1'b1;
    w = 0;
    while (!bus.input_ready && w < MAX_WAIT) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= MAX_WAIT) begin
      errors++;
      $display("FAIL send_ready_timeout pos=%0d got input_ready=%b want 1", p, bus.input_ready);
    end
    @(posedge clk);
    #1;
    bus.input_valid = 1'b0;
  endtask

  // Count edges until output_valid; start is the edge count already elapsed.
  task automatic wait_out(input int start, output int lat, output bit to);
    lat = start;
    to  = 1'b0;
    while (!bus.output_valid) begin
      if (lat >= MAX_WAIT) begin
        to = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.input_ready !== 1'b0 || bus.output_valid !== 1'b0 || bus.output_num !== '0 ||
        bus.output_mask !== '0 || bus.output_pos !== 8'd0 || bus.output_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b num=%h mask=%h pos=%0d err=%b want all 0",
               bus.input_ready, bus.output_valid, bus.output_num, bus.output_mask,
               bus.output_pos, bus.output_err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.input_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", bus.input_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] plist [7];
    int lat;
    bit to;
    exp_t e;
    plist[0] = 8'd13; plist[1] = 8'd0;  plist[2] = 8'd63; plist[3] = 8'hFF;
    plist[4] = 8'd64; plist[5] = 8'd1;  plist[6] = 8'd200;
    for (int k = 0; k < 7; k++) begin
      send(plist[k]);
      wait_out(1, lat, to);
      e = sb.pop_front();
      checks++;
      if (to) begin
        errors++;
        $display("FAIL basic_timeout pos=%0d no output_valid within %0d edges", plist[k], MAX_WAIT);
        continue;
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL basic_latency pos=%0d got %0d want %0d", plist[k], lat, e.lat);
      end
      checks++;
      if (bus.output_num !== e.num) begin
        errors++;
        $display("FAIL basic_num pos=%0d got %h want %h", plist[k], bus.output_num, e.num);
      end
      checks++;
      if (bus.output_mask !== e.mask) begin
        errors++;
        $display("FAIL basic_mask pos=%0d got %h want %h", plist[k], bus.output_mask, e.mask);
      end
      checks++;
      if (bus.output_pos !== e.pos || bus.output_err !== e.err) begin
        errors++;
        $display("FAIL basic_pos_err pos=%0d got pos=%0d err=%b want pos=%0d err=%b",
                 plist[k], bus.output_pos, bus.output_err, e.pos, e.err);
      end
      if (!e.err && e.pos != 8'hFF) begin
        checks++;
        if (bus.output_mask !== ((bus.output_num << 1) - N'(1))) begin
          errors++;
          $display("FAIL basic_invariant pos=%0d mask=%h num=%h", plist[k], bus.output_mask,
                   bus.output_num);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    bit to;
    exp_t e;
    send(8'd61);
    lat = 1;
    repeat (4) begin
      @(negedge clk);
      bus.input_pos   = 8'd5;
      bus.input_valid = 1'b1;
      checks++;
      if (bus.input_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready got %b want 0", bus.input_ready);
      end
      @(posedge clk);
      #1;
      lat++;
      bus.input_valid = 1'b0;
    end
    wait_out(lat, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat) begin
      errors++;
      $display("FAIL busy_latency got %0d (timeout=%b) want %0d", lat, to, e.lat);
    end
    checks++;
    if (bus.output_num !== e.num || bus.output_mask !== e.mask || bus.output_pos !== 8'd61) begin
      errors++;
      $display("FAIL busy_result got num=%h mask=%h pos=%0d want num=%h mask=%h pos=61",
               bus.output_num, bus.output_mask, bus.output_pos, e.num, e.mask);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.output_valid !== 1'b0 || bus.input_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_no_queue got vld=%b rdy=%b want vld=0 rdy=1",
               bus.output_valid, bus.input_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit to;
    exp_t e;
    @(negedge clk);
    bus.output_ready = 1'b0;
    send(8'd9);
    wait_out(1, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || bus.output_num !== e.num || bus.output_mask !== e.mask) begin
      errors++;
      $display("FAIL bp_first got num=%h mask=%h timeout=%b want num=%h mask=%h",
               bus.output_num, bus.output_mask, to, e.num, e.mask);
    end
    @(negedge clk);
    bus.input_pos   = 8'd2;
    bus.input_valid = 1'b1;
    sb.push_back(model(8'd2));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.output_valid !== 1'b1 || bus.input_ready !== 1'b0 || bus.output_num !== e.num ||
          bus.output_mask !== e.mask || bus.output_pos !== 8'd9) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got vld=%b rdy=%b num=%h pos=%0d want vld=1 rdy=0 num=%h pos=9",
                 c, bus.output_valid, bus.input_ready, bus.output_num, bus.output_pos, e.num);
      end
    end
    @(negedge clk);
    bus.output_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.output_valid !== 1'b0 || bus.input_ready !== 1'b1 || bus.output_num !== e.num) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b num=%h want vld=0 rdy=1 num=%h",
               bus.output_valid, bus.input_ready, bus.output_num, e.num);
    end
    @(posedge clk);
    #1;
    bus.input_valid = 1'b0;
    checks++;
    if (bus.input_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_held_accept got rdy=%b want 0", bus.input_ready);
    end
    wait_out(1, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat || bus.output_num !== e.num || bus.output_mask !== e.mask ||
        bus.output_pos !== 8'd2) begin
      errors++;
      $display("FAIL bp_second got lat=%0d num=%h mask=%h pos=%0d want lat=%0d num=%h mask=%h pos=2",
               lat, bus.output_num, bus.output_mask, bus.output_pos, e.lat, e.num, e.mask);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    bit to;
    exp_t e;
    send(8'd20);
    repeat (13) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    void'(sb.pop_front());
    checks++;
    if (bus.output_valid !== 1'b0 || bus.output_num !== '0 || bus.output_mask !== '0 ||
        bus.output_pos !== 8'd0 || bus.output_err !== 1'b0 || bus.input_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got vld=%b num=%h mask=%h pos=%0d err=%b rdy=%b want all 0",
               bus.output_valid, bus.output_num, bus.output_mask, bus.output_pos,
               bus.output_err, bus.input_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.input_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_ready got %b want 1", bus.input_ready);
    end
    send(8'd3);
    wait_out(1, lat, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== 5 || bus.output_num !== 64'h8 || bus.output_mask !== 64'hF ||
        bus.output_num !== e.num || bus.output_mask !== e.mask) begin
      errors++;
      $display("FAIL rst_busy_fresh got lat=%0d num=%h mask=%h want lat=5 num=8 mask=f",
               lat, bus.output_num, bus.output_mask);
    end
  endtask

  initial begin
    bus.input_pos    = 8'd0;
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b1;
    test_reset();
    test_basic();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
